tick_sched: RTL

Shared-tick software timer scheduler. An internal prescaler produces one `tick` per `TICK_FREQ` period. On each tick, a single time-multiplexed decrementer services `NUM_CH` independent countdown channels, one channel per clock. Requesters start and stop channels through a valid/ready command port. The block sits between the 100 MHz system clock and any logic needing millisecond-scale timeouts, such as debounce, LED blink or FND refresh.

---
 rtl/tick_sched.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/tick_sched.sv
// tick_sched: shared-tick countdown timer scheduler.
// A prescaler emits one tick per TICK_CNT clocks. On each tick a single
// time-multiplexed decrementer walks all NUM_CH channels, one per clock.
// Channels are started and stopped through a valid/ready command port.
//
// Optional feature: define TICK_SCHED_PERIODIC_EN to make channels
// auto-reload from a stored period and run until stopped. Without the
// macro every channel is one-shot and no period registers exist.
//
// Handshake: a command transfers on a rising clk_100Mhz edge where
// cmd_valid & cmd_ready are both high. cmd_ready is high only while the
// scheduler is IDLE. The requester holds cmd_valid, cmd_op, cmd_ch and
// cmd_period stable until the transfer; cmd_ready never depends on cmd_valid.
module tick_sched #(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int TICK_FREQ = 1000,
  parameter int NUM_CH    = 4,
  parameter int CNT_W     = 16
) (
  input  logic                      clk_100Mhz,
  input  logic                      rst,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_op,
  input  logic [$clog2(NUM_CH)-1:0] cmd_ch,
  input  logic [CNT_W-1:0]          cmd_period,
  output logic [NUM_CH-1:0]         ch_active,
  output logic [NUM_CH-1:0]         expire,
  output logic                      tick,
  output logic                      dbg_state
);

  localparam int TICK_CNT = CLK_FREQ / TICK_FREQ;
  localparam int PS_W     = (TICK_CNT > 1) ? $clog2(TICK_CNT) : 1;
  localparam int CH_W     = $clog2(NUM_CH);

  localparam logic [PS_W-1:0]  PS_MAX  = PS_W'(TICK_CNT - 1);
  localparam logic [CH_W-1:0]  IDX_MAX = CH_W'(NUM_CH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // A scan takes NUM_CH clocks after the tick; the next tick must find IDLE.
  if (TICK_CNT <= NUM_CH + 1) begin : g_bad_tick_cnt
    $error("tick_sched: TICK_CNT must exceed NUM_CH + 1");
  end
  if (NUM_CH < 2) begin : g_bad_num_ch
    $error("tick_sched: NUM_CH must be at least 2");
  end

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

  state_t              r_state;
  logic [CH_W-1:0]     r_idx;
  logic [PS_W-1:0]     r_cnt;
  logic                r_tick;
  logic [NUM_CH-1:0]   r_active;
  logic [NUM_CH-1:0]   r_expire;
  logic [CNT_W-1:0]    r_remain [NUM_CH];
`ifdef TICK_SCHED_PERIODIC_EN
  logic [CNT_W-1:0]    r_period [NUM_CH];
`endif

  logic                w_ch_ok;
  logic                w_cmd_fire;

  // Channel numbers beyond NUM_CH-1 are accepted but have no effect.
  if (NUM_CH == (1 << CH_W)) begin : g_ch_full
    assign w_ch_ok = 1'b1;
  end else begin : g_ch_part
    assign w_ch_ok = (cmd_ch < CH_W'(NUM_CH));
  end

  assign cmd_ready  = (r_state == ST_IDLE);
  assign w_cmd_fire = cmd_valid & cmd_ready & w_ch_ok;

  assign ch_active  = r_active;
  assign expire     = r_expire;
  assign tick       = r_tick;
  assign dbg_state  = r_state;

  // Prescaler: free-running 0..TICK_CNT-1 counter with a registered tick.
  always_ff @(posedge clk_100Mhz or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_tick <= (r_cnt == PS_MAX);
      if (r_cnt == PS_MAX) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + PS_W'(1);
      end
    end
  end

  // Scheduler FSM: applies commands in IDLE, walks one channel per clock in SCAN.
  always_ff @(posedge clk_100Mhz or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_idx    <= '0;
      r_active <= '0;
      r_expire <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_remain[i] <= '0;
`ifdef TICK_SCHED_PERIODIC_EN
        r_period[i] <= '0;
`endif
      end
    end else begin
      // Expiry is a one-clock pulse unless re-set by this cycle's scan step.
      r_expire <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_cmd_fire) begin
            if (cmd_op) begin
              // A zero period is accepted but leaves the channel untouched.
              if (cmd_period != '0) begin
                r_remain[cmd_ch] <= cmd_period;
                r_active[cmd_ch] <= 1'b1;
`ifdef TICK_SCHED_PERIODIC_EN
                r_period[cmd_ch] <= cmd_period;
`endif
              end
            end else begin
              r_active[cmd_ch] <= 1'b0;
            end
          end
          // The command above lands first, so the following scan sees it.
          if (r_tick) begin
            r_state <= ST_SCAN;
            r_idx   <= '0;
          end
        end

        ST_SCAN: begin
          // An active channel never holds remain == 0, so else means remain == 1.
          if (r_active[r_idx]) begin
            if (r_remain[r_idx] > CNT_ONE) begin
              r_remain[r_idx] <= r_remain[r_idx] - CNT_ONE;
            end else begin
              r_expire[r_idx] <= 1'b1;
`ifdef TICK_SCHED_PERIODIC_EN
              r_remain[r_idx] <= r_period[r_idx];
`else
              r_active[r_idx] <= 1'b0;
`endif
            end
          end
          if (r_idx == IDX_MAX) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
          end else begin
            r_idx <= r_idx + CH_W'(1);
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_idx   <= '0;
        end
      endcase
    end
  end

endmodule
